// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between two requesters,
// with a tag FIFO that routes each response back to the requester that issued it.
module mem_port_arbiter #(
  parameter  int unsigned Width     = 8,
  parameter  int unsigned AddrWidth = 8,
  parameter  int unsigned TagDepth  = 4,
  localparam int unsigned ReqW      = Width + AddrWidth + 1,
  localparam int unsigned PtrW      = $clog2(TagDepth),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [ReqW-1:0]  req0,
  input  logic             req0_valid,
  output logic             req0_bp,
  input  logic [ReqW-1:0]  req1,
  input  logic             req1_valid,
  output logic             req1_bp,
  output logic [Width-1:0] resp0,
  output logic             resp0_valid,
  input  logic             resp0_bp,
  output logic [Width-1:0] resp1,
  output logic             resp1_valid,
  input  logic             resp1_bp,
  output logic [ReqW-1:0]  mem_req,
  output logic             mem_req_valid,
  input  logic             mem_req_bp,
  input  logic [Width-1:0] mem_resp,
  input  logic             mem_resp_valid,
  output logic             mem_resp_bp,
  output logic [CntW-1:0]  outstanding,
  output logic             err
);

  typedef enum logic {
    ARB_OPEN,
    ARB_HELD
  } arb_state_e;

  arb_state_e state_q, state_d;

  logic            gnt, gnt_q, gnt_d;
  logic            ptr_q, ptr_d;
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [TagDepth-1:0] tags_q;

  logic full, empty, accept, have_head, head, pop, bypass, push_fifo, pop_fifo;

  // A stalled request keeps its grant so mem_req cannot change under backpressure.
  always_comb begin
    gnt     = ptr_q;
    state_d = ARB_OPEN;
    if (state_q == ARB_HELD) begin
      gnt = gnt_q;
    end else if (req0_valid ^ req1_valid) begin
      gnt = req1_valid;
    end
    if (mem_req_valid && mem_req_bp) begin
      state_d = ARB_HELD;
    end
  end

  assign full  = (cnt_q == CntW'(TagDepth));
  assign empty = (cnt_q == '0);

  assign mem_req       = gnt ? req1 : req0;
  assign mem_req_valid = (gnt ? req1_valid : req0_valid) & ~full;
  assign req0_bp       = gnt | mem_req_bp | full;
  assign req1_bp       = ~gnt | mem_req_bp | full;
  assign accept        = mem_req_valid & ~mem_req_bp;

  // With an empty FIFO the tag being accepted right now serves a zero-latency response.
  assign have_head = ~empty | accept;
  assign head      = empty ? gnt : tags_q[rd_q];

  assign resp0       = mem_resp;
  assign resp1       = mem_resp;
  assign resp0_valid = mem_resp_valid & have_head & ~head;
  assign resp1_valid = mem_resp_valid & have_head & head;
  assign mem_resp_bp = have_head & (head ? resp1_bp : resp0_bp);

  assign pop       = mem_resp_valid & ~mem_resp_bp & have_head;
  assign bypass    = empty & accept & pop;
  assign push_fifo = accept & ~bypass;
  assign pop_fifo  = pop & ~empty;

  always_comb begin
    gnt_d = gnt;
    ptr_d = accept ? ~gnt : ptr_q;
    wr_d  = push_fifo ? wr_q + PtrW'(1) : wr_q;
    rd_d  = pop_fifo ? rd_q + PtrW'(1) : rd_q;
    cnt_d = cnt_q;
    if (push_fifo && !pop_fifo) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push_fifo && pop_fifo) begin
      cnt_d = cnt_q - CntW'(1);
    end
    err_d = err_q | (mem_resp_valid & ~have_head);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ARB_OPEN;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fifo) begin
      tags_q[wr_q] <= gnt;
    end
  end

  assign outstanding = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked against
// a request-order scoreboard and a shadow memory.
module tb_mem_port_arbiter;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned TD = 4;
  localparam int unsigned RW = W + AW + 1;

  logic clk = 1'b0;
  logic resetn;
  logic [RW-1:0] req0, req1, mem_req;
  logic req0_valid, req1_valid, req0_bp, req1_bp;
  logic [W-1:0] resp0, resp1, mem_resp;
  logic resp0_valid, resp1_valid, resp0_bp, resp1_bp;
  logic mem_req_valid, mem_req_bp, mem_resp_valid, mem_resp_bp;
  logic [$clog2(TD):0] outstanding;
  logic err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.Width(W), .AddrWidth(AW), .TagDepth(TD)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .req0_valid(req0_valid), .req0_bp(req0_bp),
    .req1(req1), .req1_valid(req1_valid), .req1_bp(req1_bp),
    .resp0(resp0), .resp0_valid(resp0_valid), .resp0_bp(resp0_bp),
    .resp1(resp1), .resp1_valid(resp1_valid), .resp1_bp(resp1_bp),
    .mem_req(mem_req), .mem_req_valid(mem_req_valid), .mem_req_bp(mem_req_bp),
    .mem_resp(mem_resp), .mem_resp_valid(mem_resp_valid), .mem_resp_bp(mem_resp_bp),
    .outstanding(outstanding), .err(err)
  );

  // Memory model: zero-latency combinational or fixed-latency queue; every request answers.
  logic       zl, resp_en, inject;
  int         lat, cyc;
  logic [7:0] ram [256];
  int         mq_rdy [16];
  logic [7:0] mq_dat [16];
  int         mq_hd, mq_cnt;

  always_comb begin
    mem_resp_valid = 1'b0;
    mem_resp       = '0;
    if (inject) begin
      mem_resp_valid = 1'b1;
      mem_resp       = 8'h5A;
    end else if (zl) begin
      mem_resp_valid = resp_en && mem_req_valid && !mem_req_bp;
      mem_resp       = mem_req[0] ? mem_req[8:1] : ram[mem_req[16:9]];
    end else if (mq_cnt > 0 && resp_en && mq_rdy[mq_hd] <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp       = mq_dat[mq_hd];
    end
  end

  // Reference model: issue order of accepted requests with expected data, plus arbitration state.
  logic       oq_who [$];
  logic [7:0] oq_dat [$];
  logic [7:0] shadow [256];
  int         stall_m;
  logic       ptr_m, err_m;

  logic acc0_s, acc1_s, macc_s, mpop_s;
  logic [RW-1:0] mreq_s;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_req();
    logic [RW-1:0] r;
    r[16:9] = 8'($urandom_range(0, 7));
    r[8:1]  = 8'($urandom);
    r[0]    = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic model_reset();
    oq_who.delete();
    oq_dat.delete();
    stall_m = -1;
    ptr_m   = 1'b0;
    err_m   = 1'b0;
    mq_hd   = 0;
    mq_cnt  = 0;
  endtask

  // Observe one cycle just before its rising edge and check it against the model.
  task automatic sample();
    logic g, vg, full, own, obp;
    logic [RW-1:0] pg, pa;
    logic [7:0] e;
    @(negedge clk);
    acc0_s = req0_valid && !req0_bp;
    acc1_s = req1_valid && !req1_bp;
    macc_s = mem_req_valid && !mem_req_bp;
    mpop_s = mem_resp_valid && !mem_resp_bp;
    mreq_s = mem_req;
    if (!resetn) return;
    chk("outstanding", 32'(outstanding), 32'(oq_who.size()));
    chk("err", 32'(err), 32'(err_m));
    full = (oq_who.size() == TD);
    if (stall_m >= 0) g = stall_m[0];
    else if (req0_valid != req1_valid) g = req1_valid;
    else g = ptr_m;
    vg = g ? req1_valid : req0_valid;
    pg = g ? req1 : req0;
    chk("mem_req_valid", 32'(mem_req_valid), 32'(vg && !full));
    if (vg && !full) chk("mem_req", 32'(mem_req), 32'(pg));
    chk("req0_bp", 32'(req0_bp), 32'(g || mem_req_bp || full));
    chk("req1_bp", 32'(req1_bp), 32'(!g || mem_req_bp || full));
    chk("accept_match", 32'(macc_s), 32'(acc0_s || acc1_s));
    if (acc0_s || acc1_s) begin
      pa = acc1_s ? req1 : req0;
      if (pa[0]) begin
        shadow[pa[16:9]] = pa[8:1];
        e = pa[8:1];
      end else begin
        e = shadow[pa[16:9]];
      end
      oq_who.push_back(acc1_s);
      oq_dat.push_back(e);
    end
    if (mem_resp_valid) begin
      if (oq_who.size() != 0) begin
        own = oq_who[0];
        obp = own ? resp1_bp : resp0_bp;
        chk("resp0_valid", 32'(resp0_valid), 32'(!own));
        chk("resp1_valid", 32'(resp1_valid), 32'(own));
        chk("resp_data", 32'(own ? resp1 : resp0), 32'(oq_dat[0]));
        chk("mem_resp_bp", 32'(mem_resp_bp), 32'(obp));
        if (!obp) begin
          void'(oq_who.pop_front());
          void'(oq_dat.pop_front());
        end
      end else begin
        chk("orphan_bp", 32'(mem_resp_bp), 32'(0));
        chk("orphan_quiet", 32'({resp0_valid, resp1_valid}), 32'(0));
        err_m = 1'b1;
      end
    end else begin
      chk("resp_idle", 32'({resp0_valid, resp1_valid}), 32'(0));
    end
    stall_m = (vg && !full && mem_req_bp) ? int'(g) : -1;
    if (macc_s) ptr_m = !g;
  endtask

  // Cross the rising edge, then advance the memory model and the requester drivers.
  task automatic adv();
    logic [7:0] d;
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (macc_s) begin
      if (mreq_s[0]) begin
        ram[mreq_s[16:9]] = mreq_s[8:1];
        d = mreq_s[8:1];
      end else begin
        d = ram[mreq_s[16:9]];
      end
      if (!zl) begin
        idx = (mq_hd + mq_cnt) % 16;
        mq_dat[idx] = d;
        mq_rdy[idx] = cyc + lat - 1;
        mq_cnt++;
      end
    end
    if (mpop_s && !inject && !zl && mq_cnt > 0) begin
      mq_hd = (mq_hd + 1) % 16;
      mq_cnt--;
    end
    if (acc0_s) req0_valid = 1'b0;
    if (acc1_s) req1_valid = 1'b0;
  endtask

  task automatic cyc1();
    sample();
    adv();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    sample();
    while (!(outstanding == 0 && !req0_valid && !req1_valid) && n < limit) begin
      adv();
      sample();
      n++;
    end
    chk("drain_outstanding", 32'(outstanding), 32'(0));
    adv();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_who;
    logic [RW-1:0] p0, p1;
    int n;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    cyc = 0; lat = 3; zl = 1'b1; resp_en = 1'b1; inject = 1'b0;
    req0 = '0; req1 = '0; req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_bp = 1'b0; resp1_bp = 1'b0; mem_req_bp = 1'b0;
    model_reset();

    resetn = 1'b0;
    cyc1(); cyc1();
    resetn = 1'b1;
    sample();
    chk("rst_outstanding", 32'(outstanding), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_req0_bp", 32'(req0_bp), 32'(0));
    chk("rst_req1_bp", 32'(req1_bp), 32'(1));
    adv();

    // Zero-latency write then read through requester 0.
    req0 = {8'h10, 8'hA5, 1'b1}; req0_valid = 1'b1;
    cyc1();
    req0 = {8'h10, 8'h00, 1'b0}; req0_valid = 1'b1;
    sample();
    chk("zl_read_valid", 32'(resp0_valid), 32'(1));
    chk("zl_read_data", 32'(resp0), 32'(8'hA5));
    chk("zl_resp1_quiet", 32'(resp1_valid), 32'(0));
    adv();

    // Both requesters continuously valid from reset: strict alternation starting at 0.
    resetn = 1'b0; cyc1(); resetn = 1'b1;
    exp_who = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req0 = {8'h01, 8'h00, 1'b0}; req1 = {8'h02, 8'h00, 1'b0};
      req0_valid = 1'b1; req1_valid = 1'b1;
      sample();
      chk("rr_order", 32'(acc1_s), 32'(exp_who));
      chk("rr_single", 32'(acc0_s ^ acc1_s), 32'(1));
      chk("rr_route", 32'(resp1_valid), 32'(exp_who));
      exp_who = ~exp_who;
      adv();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Stall with req0 granted; req1 arrives mid-stall and must wait.
    p0 = {8'h20, 8'h3C, 1'b1}; p1 = {8'h21, 8'hC3, 1'b1};
    req0 = p0; req0_valid = 1'b1; mem_req_bp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("stall_payload", 32'(mem_req), 32'(p0));
      chk("stall_req1_bp", 32'(req1_bp), 32'(1));
      chk("stall_valid", 32'(mem_req_valid), 32'(1));
      adv();
      req1 = p1; req1_valid = 1'b1;
    end
    mem_req_bp = 1'b0;
    sample();
    chk("release_req0_bp", 32'(req0_bp), 32'(0));
    chk("release_payload", 32'(mem_req), 32'(p0));
    chk("release_req1_bp", 32'(req1_bp), 32'(1));
    adv();
    sample();
    chk("next_grant", 32'(req1_bp), 32'(0));
    chk("next_payload", 32'(mem_req), 32'(p1));
    adv();

    // Latency-3 memory holding its responses: the tag FIFO fills at TD.
    zl = 1'b0; lat = 3; resp_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req0 = rand_req(); req0[0] = 1'b0; req1 = rand_req(); req1[0] = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      cyc1();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    sample();
    chk("full_outstanding", 32'(outstanding), 32'(4));
    chk("full_req0_bp", 32'(req0_bp), 32'(1));
    chk("full_req1_bp", 32'(req1_bp), 32'(1));
    chk("full_mem_req_valid", 32'(mem_req_valid), 32'(0));
    adv();
    resp_en = 1'b1;
    sample();
    chk("full_pop_valid", 32'(mem_resp_valid), 32'(1));
    chk("full_pop_route", 32'(resp0_valid), 32'(1));
    adv();
    resp_en = 1'b0;
    sample();
    chk("resume_outstanding", 32'(outstanding), 32'(3));
    chk("resume_valid", 32'(mem_req_valid), 32'(1));
    adv();
    req0_valid = 1'b0; req1_valid = 1'b0; resp_en = 1'b1;
    drain(40);

    // Response backpressure on requester 1 while its response is at the head.
    resp1_bp = 1'b1;
    req1 = {8'h21, 8'h00, 1'b0}; req1_valid = 1'b1;
    cyc1();
    req0 = {8'h20, 8'h00, 1'b0}; req0_valid = 1'b1;
    cyc1();
    n = 0;
    sample();
    while (!mem_resp_valid && n < 10) begin
      adv();
      sample();
      n++;
    end
    chk("hold_valid", 32'(mem_resp_valid), 32'(1));
    chk("hold_bp", 32'(mem_resp_bp), 32'(1));
    chk("hold_route1", 32'(resp1_valid), 32'(1));
    chk("hold_route0", 32'(resp0_valid), 32'(0));
    adv();
    sample();
    chk("hold_still", 32'(resp1_valid), 32'(1));
    chk("hold_outstanding", 32'(outstanding), 32'(2));
    adv();
    resp1_bp = 1'b0;
    sample();
    chk("release_resp_bp", 32'(mem_resp_bp), 32'(0));
    chk("release_resp1", 32'(resp1_valid), 32'(1));
    chk("release_data", 32'(resp1), 32'(8'hC3));
    adv();
    sample();
    chk("queued_resp0", 32'(resp0_valid), 32'(1));
    chk("queued_data", 32'(resp0), 32'(8'h3C));
    adv();
    drain(20);

    // Random traffic with random stalls on every channel.
    lat = 2;
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin req0 = rand_req(); req0_valid = 1'b1; end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin req1 = rand_req(); req1_valid = 1'b1; end
      mem_req_bp = ($urandom_range(0, 3) == 0);
      resp0_bp   = ($urandom_range(0, 3) == 0);
      resp1_bp   = ($urandom_range(0, 3) == 0);
      resp_en    = ($urandom_range(0, 3) != 0);
      cyc1();
    end
    mem_req_bp = 1'b0; resp0_bp = 1'b0; resp1_bp = 1'b0; resp_en = 1'b1;
    drain(60);

    // Orphan response, sticky err, then reset with a request in flight.
    inject = 1'b1;
    sample();
    chk("inject_bp", 32'(mem_resp_bp), 32'(0));
    adv();
    inject = 1'b0;
    sample();
    chk("err_set", 32'(err), 32'(1));
    adv();
    resp_en = 1'b0;
    req0 = {8'h05, 8'h00, 1'b0}; req0_valid = 1'b1;
    cyc1(); cyc1();
    sample();
    chk("err_sticky", 32'(err), 32'(1));
    chk("inflight", 32'(outstanding), 32'(1));
    adv();
    resetn = 1'b0; cyc1(); resetn = 1'b1;
    sample();
    chk("rst_err_clr", 32'(err), 32'(0));
    chk("rst_outstanding_clr", 32'(outstanding), 32'(0));
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
